uart_pgload_16: RTL and testbench

UART program loader that receives a length-prefixed image over the serial line, assembles 16-bit words and writes them into the instruction block memory. It drives the S86 system's program-download slave port: clock, write-enable, address, data and done. It replaces the vendor downloader core in the SoC top and runs from the 10 MHz system clock while the download reset is released. After the last word it returns one status byte on TX.

---
 rtl/uart_pgload_16_pkg.sv | 8 +
 rtl/uart_pgload_16_rx.sv | 61 ++++++
 rtl/uart_pgload_16.sv | 101 ++++++++++
 tb/tb_uart_pgload_16.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pgload_16_pkg.sv
// s86_pg_pkg: shared loader FSM states, RX engine states, status codes and default bit timing
package s86_pg_pkg;
  typedef enum logic [2:0] {HDR_LO, HDR_HI, W_LO, W_HI, STATUS, DONE, ERR} pg_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h45;
  localparam int DEF_CLKS_PER_BIT = 87;
endpackage

// File: rtl/uart_pgload_16_rx.sv
// uart_rx_byte: 8N1 receiver with synchronizer, glitch-rejecting start detect and stop-bit check
module uart_rx_byte
  import s86_pg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  rx_state_t     rs;
  logic          s1, s2, s3;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
      rs <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      byte_data <= '0;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      cnt <= cnt + 1'b1;
      case (rs)
        RX_IDLE: begin
          cnt <= '0;
          if (s3 && !s2) rs <= RX_START;
        end
        RX_START: if (cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          cnt <= '0;
          idx <= '0;
          rs <= s2 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt <= '0;
          byte_data <= {s2, byte_data[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) rs <= RX_STOP;
        end
        default: if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          byte_valid <= s2;
          frame_err <= !s2;
          rs <= RX_IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_pgload_16.sv
// uart_pgload_16: UART program loader writing length-prefixed 16-bit words to instruction memory
module uart_pgload_16
  import s86_pg_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int ADR_W = 16
) (
  input  logic             upg_clk_i,
  input  logic             upg_rst_i,
  input  logic             upg_rx_i,
  output logic             upg_tx_o,
  output logic             upg_clk_o,
  output logic             upg_wen_o,
  output logic [ADR_W-1:0] upg_adr_o,
  output logic [15:0]      upg_dat_o,
  output logic             upg_done_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  pg_state_t     st;
  logic          bv, ferr, go;
  logic [7:0]    bd, code, go_code;
  logic [15:0]   rem;
  logic [9:0]    sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  assign upg_clk_o = upg_clk_i;
  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(upg_clk_i),
    .rst(upg_rst_i),
    .rx(upg_rx_i),
    .byte_valid(bv),
    .byte_data(bd),
    .frame_err(ferr)
  );
  logic hdr_zero, last, err;
  always_comb begin
    hdr_zero = st == HDR_HI && bv && {bd, rem[7:0]} == 16'd0;
    last = st == W_HI && upg_wen_o && rem == 16'd1;
    err = ferr && (st == HDR_LO || st == HDR_HI || st == W_LO || st == W_HI);
    go = hdr_zero || last || err;
    go_code = err ? NAK : ACK;
  end
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      st <= HDR_LO;
      upg_wen_o <= 1'b0;
      upg_adr_o <= '0;
      upg_dat_o <= '0;
      upg_done_o <= 1'b0;
      upg_tx_o <= 1'b1;
      rem <= '0;
      sh <= '1;
      tx_bit <= '0;
      tx_cnt <= '0;
      code <= ACK;
    end else begin
      upg_wen_o <= 1'b0;
      upg_tx_o <= st == STATUS ? sh[0] : 1'b1;
      case (st)
        HDR_LO: if (bv) begin
          rem[7:0] <= bd;
          st <= HDR_HI;
        end
        HDR_HI: if (bv) begin
          rem[15:8] <= bd;
          st <= W_LO;
        end
        W_LO: if (bv) begin
          upg_dat_o[7:0] <= bd;
          st <= W_HI;
        end
        W_HI: if (upg_wen_o) begin
          upg_adr_o <= upg_adr_o + 1'b1;
          rem <= rem - 16'd1;
          st <= W_LO;
        end else if (bv) begin
          upg_dat_o[15:8] <= bd;
          upg_wen_o <= 1'b1;
        end
        STATUS: if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
          tx_cnt <= '0;
          sh <= {1'b0, sh[9:1]};
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 4'd9) begin
            st <= code == ACK ? DONE : ERR;
            upg_done_o <= code == ACK;
          end
        end else tx_cnt <= tx_cnt + 1'b1;
        default: ;
      endcase
      // entering STATUS overrides the per-state next state chosen above
      if (go) begin
        st <= STATUS;
        code <= go_code;
        sh <= {1'b1, go_code, 1'b0};
        tx_bit <= '0;
        tx_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_uart_pgload_16.sv
// tb_uart_pgload_16: table-driven image downloads plus hand-written glitch and mid-image reset sequences
module tb_uart_pgload_16;
  import s86_pg_pkg::*;
  localparam int CPB = 8;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic upg_tx_o, upg_clk_o, upg_wen_o, upg_done_o;
  logic [15:0] upg_adr_o, upg_dat_o;
  int tests = 0, fails = 0, clk_bad = 0;
  logic [31:0] writes[$];
  logic [7:0] tx_q[$];
  always #5 clk = ~clk;
  uart_pgload_16 #(.CLKS_PER_BIT(CPB), .ADR_W(16)) dut (
    .upg_clk_i(clk),
    .upg_rst_i(rst),
    .upg_rx_i(rx),
    .upg_tx_o(upg_tx_o),
    .upg_clk_o(upg_clk_o),
    .upg_wen_o(upg_wen_o),
    .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  logic prev_wen = 1'b0, prev_bv = 1'b0;
  logic [15:0] prev_adr = '0, prev_dat = '0;
  always @(negedge clk) begin
    if (upg_clk_o !== 1'b0) clk_bad++;
    if (upg_wen_o === 1'b1) begin
      writes.push_back({upg_adr_o, upg_dat_o});
      check("wen_latency", {31'd0, prev_bv}, 1);
    end
    if (prev_wen) begin
      check("wen_width", {31'd0, upg_wen_o}, 0);
      check("adr_inc", {16'd0, upg_adr_o}, {16'd0, 16'(prev_adr + 16'd1)});
      check("dat_hold", {16'd0, upg_dat_o}, {16'd0, prev_dat});
    end
    prev_wen = upg_wen_o;
    prev_bv = dut.u_rx.byte_valid;
    prev_adr = upg_adr_o;
    prev_dat = upg_dat_o;
  end
  always @(posedge clk) begin
    #1;
    if (upg_clk_o !== 1'b1) clk_bad++;
  end
  logic [7:0] tb;
  always begin
    @(negedge clk);
    if (upg_tx_o === 1'b0) begin
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        tb[i] = upg_tx_o;
      end
      repeat (CPB) @(negedge clk);
      check("tx_stop", {31'd0, upg_tx_o}, 1);
      tx_q.push_back(tb);
    end
  end
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    writes.delete();
    tx_q.delete();
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_tx(output logic [7:0] b);
    b = 8'hxx;
    for (int i = 0; i < 3000 && tx_q.size() == 0; i++) @(negedge clk);
    check("tx_seen", {31'd0, tx_q.size() != 0}, 1);
    if (tx_q.size() != 0) b = tx_q.pop_front();
  endtask
  typedef struct packed {
    int n;
    logic [63:0] bytes;
    logic bad_stop;
    logic glitch;
    int nw;
    logic [63:0] w;
    logic [7:0] tx;
    logic done;
    pg_state_t st;
  } vec_t;
  vec_t vecs[4];
  logic [7:0] got;
  initial begin
    vecs[0] = '{n: 6, bytes: 64'h0000_5678_1234_0002, bad_stop: 0, glitch: 0, nw: 2,
                w: 64'h0001_5678_0000_1234, tx: 8'h4B, done: 1, st: DONE};
    vecs[1] = '{n: 2, bytes: 64'h0, bad_stop: 0, glitch: 0, nw: 0,
                w: 64'h0, tx: 8'h4B, done: 1, st: DONE};
    vecs[2] = '{n: 4, bytes: 64'h12CD_0001, bad_stop: 1, glitch: 0, nw: 0,
                w: 64'h0, tx: 8'h45, done: 0, st: ERR};
    vecs[3] = '{n: 4, bytes: 64'hBEEF_0001, bad_stop: 0, glitch: 1, nw: 1,
                w: 64'h0000_BEEF, tx: 8'h4B, done: 1, st: DONE};
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, upg_tx_o}, 1);
    check("rst_wen", {31'd0, upg_wen_o}, 0);
    check("rst_adr", {16'd0, upg_adr_o}, 0);
    check("rst_dat", {16'd0, upg_dat_o}, 0);
    check("rst_done", {31'd0, upg_done_o}, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      do_reset();
      if (vecs[k].glitch) begin
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_state", {29'd0, dut.st}, {29'd0, HDR_LO});
      end
      for (int i = 0; i < vecs[k].n; i++)
        send_byte(vecs[k].bytes[8*i +: 8], !(vecs[k].bad_stop && i == vecs[k].n - 1));
      wait_tx(got);
      check("tx_code", {24'd0, got}, {24'd0, vecs[k].tx});
      check("done_in_stop", {31'd0, upg_done_o}, 0);
      repeat (10) @(negedge clk);
      check("done", {31'd0, upg_done_o}, {31'd0, vecs[k].done});
      check("final_state", {29'd0, dut.st}, {29'd0, vecs[k].st});
      check("n_writes", writes.size(), vecs[k].nw);
      for (int i = 0; i < vecs[k].nw && i < writes.size(); i++)
        check("write", writes[i], vecs[k].w[32*i +: 32]);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b1);
      repeat (20) @(negedge clk);
      check("post_writes", writes.size(), vecs[k].nw);
      check("post_tx", tx_q.size(), 0);
      check("post_done", {31'd0, upg_done_o}, {31'd0, vecs[k].done});
    end
    do_reset();
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (CPB + CPB * 3 + 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    check("rst_mid_writes", writes.size(), 1);
    check("rst_mid_w0", writes.size() > 0 ? writes[0] : 32'hFFFF_FFFF, 32'h0000_1111);
    repeat (20) @(negedge clk);
    check("rst_after_writes", writes.size(), 1);
    check("rst_after_state", {29'd0, dut.st}, {29'd0, HDR_LO});
    check("rst_after_adr", {16'd0, upg_adr_o}, 0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    wait_tx(got);
    check("img2_tx", {24'd0, got}, 32'h4B);
    repeat (10) @(negedge clk);
    check("img2_writes", writes.size(), 2);
    check("img2_w", writes.size() > 1 ? writes[1] : 32'hFFFF_FFFF, 32'h0000_DEAD);
    check("img2_done", {31'd0, upg_done_o}, 1);
    check("clk_o", clk_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
